// File: rtl/apb_master_if.sv
// Bundles the command, response and APB signals of apb_master.
// Latency: none; this is wiring only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; APB waits via PREADY.
//
// Modports:
//   master - seen by apb_master: command/response client side plus the APB requester pins
//   slave  - seen by the environment: drives commands, consumes responses, models the APB slave
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // command stream
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    // response stream
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    // APB4 requester pins
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS transfer, valid/ready response out.
// Latency: accept at edge N -> PSEL after N, PENABLE after N+1, rsp_valid after N+2 (+1 per PREADY-low cycle).
// Backpressure: cmd_ready only in IDLE; rsp_valid and response data hold until rsp_ready; APB waits via PREADY.
//
// Ports:
//   PCLK     - clock, all logic on the rising edge
//   PRESETn  - synchronous active-low reset; drops any in-flight command without a response
//   bus      - apb_master_if.master: cmd_* (in, cmd_ready out), rsp_* (out, rsp_ready in),
//              PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB (out), PREADY/PRDATA/PSLVERR (in)
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// cycles with PREADY low (response flagged with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0).
// Without it ACCESS waits indefinitely and rsp_timeout is constant 0.
//
// Every output comes straight from a flop; there is no input-to-output combinational path.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Latched command; also directly drives the APB address/control/data pins.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } cmd_t;

    // Captured completion status.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    rsp_t   rsp_q, rsp_d;

    logic psel_q,      psel_d;
    logic penable_q,   penable_d;
    logic rsp_valid_q, rsp_valid_d;
    logic cmd_ready_q, cmd_ready_d;

    logic accept;       // command handshake this cycle
    logic xfer_done;    // slave completes the ACCESS phase this cycle
    logic timeout_hit;  // watchdog aborts the ACCESS phase this cycle

    // cmd_ready_q is high exactly when the FSM sits in IDLE out of reset.
    assign accept    = bus.cmd_valid & cmd_ready_q;
    assign xfer_done = (state_q == ST_ACCESS) & bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counts completed PREADY-low ACCESS cycles; the cycle being evaluated is wait_q+1.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_q, wait_d;

    // PREADY=1 on the last allowed cycle is a normal completion, so timeout needs PREADY low.
    assign timeout_hit = (state_q == ST_ACCESS) & ~bus.PREADY &
                         (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q == ST_SETUP) begin
            wait_d = '0;
        end else if ((state_q == ST_ACCESS) && !bus.PREADY && !timeout_hit) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_done || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Decoded from the next state so the control
    // pins can be registered and still line up with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: command latch and response capture
    // ------------------------------------------------------------------
    always_comb begin
        cmd_d = cmd_q;
        if (accept) begin
            cmd_d.write = bus.cmd_write;
            cmd_d.addr  = bus.cmd_addr;
            // Reads never present write data or strobes on the bus.
            cmd_d.wdata = bus.cmd_write ? bus.cmd_wdata : '0;
            cmd_d.strb  = bus.cmd_write ? bus.cmd_strb  : '0;
        end
    end

    always_comb begin
        rsp_d = rsp_q;
        if (xfer_done) begin
            // Read data is returned even alongside PSLVERR; writes always return zero.
            rsp_d.rdata   = cmd_q.write ? '0 : bus.PRDATA;
            rsp_d.slverr  = bus.PSLVERR;
            rsp_d.timeout = 1'b0;
        end else if (timeout_hit) begin
            rsp_d.rdata   = '0;
            rsp_d.slverr  = 1'b1;
            rsp_d.timeout = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            cmd_q <= cmd_d;
            rsp_q <= rsp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata;
    assign bus.rsp_slverr  = rsp_q.slverr;
    // Without the watchdog this flop can never be set and folds to constant 0.
    assign bus.rsp_timeout = rsp_q.timeout;

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = cmd_q.write;
    assign bus.PADDR   = cmd_q.addr;
    assign bus.PWDATA  = cmd_q.wdata;
    assign bus.PSTRB   = cmd_q.strb;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected responses, a monitor pops on each handshake.
module tb_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: samples on the falling edge, pops one expectation per handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_rdata",   bus.rsp_rdata,   e.rdata);
                    check("mon_slverr",  bus.rsp_slverr,  e.slverr);
                    check("mon_timeout", bus.rsp_timeout, e.timeout);
                end
            end
        end
    end

    // One complete transfer. waits = PREADY-low ACCESS cycles before the final ACCESS cycle,
    // fin_ready = PREADY on that final cycle (0 means the watchdog should abort),
    // hold = cycles rsp_valid is held with rsp_ready low.
    task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] strb, input int waits,
                        input logic fin_ready, input logic [DW-1:0] prdata, input logic slverr,
                        input int hold);
        exp_t          e;
        logic [DW-1:0] exp_wd;
        logic [3:0]    exp_st;
        exp_wd = wr ? wdata : '0;
        exp_st = wr ? strb : 4'h0;
        if (fin_ready) begin
            e.rdata   = wr ? '0 : prdata;
            e.slverr  = slverr;
            e.timeout = 1'b0;
        end else begin
            e.rdata   = '0;
            e.slverr  = 1'b1;
            e.timeout = 1'b1;
        end

        check({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_idle_psel"},      bus.PSEL,      0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.rsp_ready = (hold == 0);
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'hFFFF_FFFF;
        bus.PSLVERR   = 1'b1;
        exp_q.push_back(e);

        step();  // edge N: accept
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = ~addr;
        bus.cmd_wdata = ~wdata;
        bus.cmd_strb  = ~strb;
        check({tag, "_setup_psel"},      bus.PSEL,      1);
        check({tag, "_setup_penable"},   bus.PENABLE,   0);
        check({tag, "_setup_cmd_ready"}, bus.cmd_ready, 0);
        check({tag, "_setup_paddr"},     bus.PADDR,     addr);
        check({tag, "_setup_pwrite"},    bus.PWRITE,    wr);
        check({tag, "_setup_pwdata"},    bus.PWDATA,    exp_wd);
        check({tag, "_setup_pstrb"},     bus.PSTRB,     exp_st);

        step();  // edge N+1: ACCESS
        check({tag, "_access_psel"},    bus.PSEL,    1);
        check({tag, "_access_penable"}, bus.PENABLE, 1);

        for (int i = 0; i < waits; i++) begin
            step();
            check({tag, "_wait_penable"},   bus.PENABLE,   1);
            check({tag, "_wait_rsp_valid"}, bus.rsp_valid, 0);
            check({tag, "_wait_paddr"},     bus.PADDR,     addr);
            check({tag, "_wait_pstrb"},     bus.PSTRB,     exp_st);
        end

        bus.PREADY  = fin_ready;
        bus.PRDATA  = prdata;
        bus.PSLVERR = slverr;
        step();  // completion or abort
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hFFFF_FFFF;
        bus.PSLVERR = 1'b1;
        check({tag, "_resp_valid"},     bus.rsp_valid, 1);
        check({tag, "_resp_psel"},      bus.PSEL,      0);
        check({tag, "_resp_penable"},   bus.PENABLE,   0);
        check({tag, "_resp_cmd_ready"}, bus.cmd_ready, 0);

        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                step();
                check({tag, "_hold_valid"},     bus.rsp_valid, 1);
                check({tag, "_hold_rdata"},     bus.rsp_rdata, e.rdata);
                check({tag, "_hold_slverr"},    bus.rsp_slverr, e.slverr);
                check({tag, "_hold_cmd_ready"}, bus.cmd_ready, 0);
            end
            bus.rsp_ready = 1'b1;
        end

        step();  // response handshake
        check({tag, "_done_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_done_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_done_paddr"},     bus.PADDR,     addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_psel",        bus.PSEL,        0);
        check("rst_penable",     bus.PENABLE,     0);
        check("rst_pwrite",      bus.PWRITE,      0);
        check("rst_paddr",       bus.PADDR,       0);
        check("rst_pwdata",      bus.PWDATA,      0);
        check("rst_pstrb",       bus.PSTRB,       0);
        check("rst_rsp_valid",   bus.rsp_valid,   0);
        check("rst_rsp_slverr",  bus.rsp_slverr,  0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_rsp_rdata",   bus.rsp_rdata,   0);
        check("rst_cmd_ready",   bus.cmd_ready,   0);
        rst_n = 1'b1;
        step();
        check("rst_release_cmd_ready", bus.cmd_ready, 1);

        // Zero-wait write; PRDATA is non-zero at completion but a write must return 0.
        xfer("wr",     1'b1, 32'h4,   32'hDEAD_BEEF, 4'hF, 0, 1'b1, 32'h55AA_55AA, 1'b0, 0);
        // Read with three wait states.
        xfer("rd_wait", 1'b0, 32'h8,  32'hCAFE_F00D, 4'hF, 3, 1'b1, 32'h1234_5678, 1'b0, 0);
        // Read with slave error still returns data.
        xfer("rd_err", 1'b0, 32'h40,  32'h0,         4'h0, 0, 1'b1, 32'h0000_0BAD, 1'b1, 0);
        // Write with response back-pressure for 5 cycles.
        xfer("wr_bp",  1'b1, 32'h100, 32'hA5A5_5A5A, 4'h3, 1, 1'b1, 32'h0,         1'b0, 5);
        // Read with back-pressure, and write with slave error.
        xfer("rd_bp",  1'b0, 32'h1FC, 32'h0,         4'hF, 2, 1'b1, 32'h0BAD_CAFE, 1'b0, 2);
        xfer("wr_err", 1'b1, 32'h200, 32'h0102_0304, 4'h9, 0, 1'b1, 32'h7777_7777, 1'b1, 0);

        // Reset during the second ACCESS wait cycle drops the transfer silently.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h80;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b1;
        bus.PREADY    = 1'b0;
        step();  // accept
        bus.cmd_valid = 1'b0;
        step();  // ACCESS, first wait cycle
        step();  // second wait cycle
        check("rstmid_penable", bus.PENABLE, 1);
        rst_n = 1'b0;
        step();
        check("rstmid_psel",      bus.PSEL,      0);
        check("rstmid_penable0",  bus.PENABLE,   0);
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_cmd_ready", bus.cmd_ready, 0);
        check("rstmid_paddr",     bus.PADDR,     0);
        rst_n      = 1'b1;
        bus.PREADY = 1'b1;
        step();
        check("rstmid_rel_cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_no_rsp",  bus.rsp_valid, 0);
            check("rstmid_no_psel", bus.PSEL,      0);
        end
        bus.PREADY = 1'b0;

        // Recovery after reset.
        xfer("post_rst", 1'b0, 32'hC, 32'h0, 4'h0, 1, 1'b1, 32'hFEED_0001, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY low for all 16 ACCESS cycles -> abort.
        xfer("tmo_abort", 1'b0, 32'h300, 32'h0, 4'h0, 15, 1'b0, 32'h1111_2222, 1'b0, 0);
        // PREADY high exactly on the 16th ACCESS cycle -> normal completion.
        xfer("tmo_edge",  1'b0, 32'h304, 32'h0, 4'h0, 15, 1'b1, 32'h3333_4444, 1'b0, 0);
`else
        // Without the watchdog a long wait still completes normally.
        xfer("long_wait", 1'b0, 32'h300, 32'h0, 4'h0, 20, 1'b1, 32'h3333_4444, 1'b0, 0);
`endif

        step();
        step();
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
